// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader. Collects a 4-byte little-endian
// word count, validates it against the instruction-memory window, then
// assembles little-endian 32-bit words and writes each one through a
// single-word memory port. Ends in DONE (load_done) or ERR (load_error).
module program_loader #(
   parameter int ADDR_W    = 12,
   parameter int BASE_WORD = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [2:0] S_HDR   = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   // Largest count that fits between BASE_WORD and the top of memory.
   // Computed in 33 bits so any 32-bit header compares without truncation.
   localparam logic [32:0]       N_LIMIT   = (33'd1 << ADDR_W) - 33'(BASE_WORD);
   localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);

   logic [2:0]      state_q, state_d;
   logic [31:0]     count_q, count_d;
   logic [1:0]      byte_idx_q, byte_idx_d;
   logic [23:0]     word_q, word_d;        // lanes 0..2 of the word in flight
   logic [31:0]     wdata_q, wdata_d;
   logic [ADDR_W:0] words_q, words_d;

   logic            accept_s;
   logic            bad_count_s;
   logic [ADDR_W:0] words_next_s;
   logic            last_word_s;

   assign accept_s     = rx_valid & rx_ready;
   assign bad_count_s  = (count_q == 32'd0) || ({1'b0, count_q} > N_LIMIT);
   assign words_next_s = words_q + {{ADDR_W{1'b0}}, 1'b1};
   assign last_word_s  = (33'(words_next_s) == {1'b0, count_q});

   // Next-state and datapath decode for the load sequence.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      wdata_d    = wdata_q;
      words_d    = words_q;
      case (state_q)
         S_HDR: begin
            if (accept_s) begin
               // Right shift: after four bytes the first one sits in [7:0].
               count_d    = {rx_data, count_q[31:8]};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_HDR;
               end
            end else begin
               state_d = S_HDR;
            end
         end
         S_CHECK: begin
            byte_idx_d = 2'd0;
            words_d    = '0;
            if (bad_count_s) begin
               state_d = S_ERR;
            end else begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept_s) begin
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  wdata_d = {rx_data, word_q};
                  state_d = S_WRITE;
               end else begin
                  word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
                  state_d = S_DATA;
               end
            end else begin
               state_d = S_DATA;
            end
         end
         S_WRITE: begin
            words_d = words_next_s;
            if (last_word_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DATA;
            end
         end
         S_DONE:  state_d = S_DONE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_HDR;
      endcase
   end

   // State and datapath registers; reset overrides every transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_HDR;
         count_q    <= 32'd0;
         byte_idx_q <= 2'd0;
         word_q     <= 24'd0;
         wdata_q    <= 32'd0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         wdata_q    <= wdata_d;
         words_q    <= words_d;
      end
   end

   // Outputs decode registered state only; no path from rx_valid to rx_ready.
   assign rx_ready     = (state_q == S_HDR) || (state_q == S_DATA);
   assign mem_we       = (state_q == S_WRITE);
   assign load_done    = (state_q == S_DONE);
   assign load_error   = (state_q == S_ERR);
   assign mem_addr     = BASE_ADDR + words_q[ADDR_W-1:0];
   assign mem_wdata    = wdata_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed byte streams into two loader instances
// (A: ADDR_W=12, BASE_WORD=3; B: ADDR_W=4, BASE_WORD=0). Expected memory
// writes are queued by the stimulus and popped by per-instance monitors.
module tb_program_loader;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data_a = 8'd0, rx_data_b = 8'd0;
   logic        rx_valid_a = 1'b0, rx_valid_b = 1'b0;
   logic        rx_ready_a, rx_ready_b;
   logic        mem_we_a, mem_we_b;
   logic [11:0] mem_addr_a;
   logic [3:0]  mem_addr_b;
   logic [31:0] mem_wdata_a, mem_wdata_b;
   logic        load_done_a, load_done_b;
   logic        load_error_a, load_error_b;
   logic [12:0] words_loaded_a;
   logic [4:0]  words_loaded_b;

   int n_cmp = 0;
   int n_fail = 0;
   wr_t exp_a[$];
   wr_t exp_b[$];
   logic throttle = 1'b0;
   logic cnt_en = 1'b0;
   int   idle_cnt = 0;

   program_loader #(.ADDR_W(12), .BASE_WORD(3)) dut_a (
      .clk(clk), .reset(reset), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
      .rx_ready(rx_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .load_done(load_done_a), .load_error(load_error_a),
      .words_loaded(words_loaded_a));

   program_loader #(.ADDR_W(4), .BASE_WORD(0)) dut_b (
      .clk(clk), .reset(reset), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
      .rx_ready(rx_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .load_done(load_done_b), .load_error(load_error_b),
      .words_loaded(words_loaded_b));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Monitor A: every write strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (mem_we_a) begin
         n_cmp++;
         if (exp_a.size() == 0) begin
            n_fail++;
            $display("FAIL wr_a_unexpected: got addr=%h data=%h, expected no write", mem_addr_a, mem_wdata_a);
         end else begin
            wr_t e;
            e = exp_a.pop_front();
            if (mem_addr_a !== e.addr || mem_wdata_a !== e.data) begin
               n_fail++;
               $display("FAIL wr_a: got addr=%h data=%h, expected addr=%h data=%h",
                        mem_addr_a, mem_wdata_a, e.addr, e.data);
            end
         end
      end
   end

   // Monitor B: same scoreboard check for the 4-bit-address instance.
   always @(negedge clk) begin
      if (mem_we_b) begin
         n_cmp++;
         if (exp_b.size() == 0) begin
            n_fail++;
            $display("FAIL wr_b_unexpected: got addr=%h data=%h, expected no write", mem_addr_b, mem_wdata_b);
         end else begin
            wr_t e;
            e = exp_b.pop_front();
            if (12'(mem_addr_b) !== e.addr || mem_wdata_b !== e.data) begin
               n_fail++;
               $display("FAIL wr_b: got addr=%h data=%h, expected addr=%h data=%h",
                        mem_addr_b, mem_wdata_b, e.addr, e.data);
            end
         end
      end
   end

   // Counts not-ready cycles of instance A while a load is in progress.
   always @(negedge clk) begin
      if (cnt_en && !rx_ready_a && !load_done_a && !load_error_a) idle_cnt++;
   end

   task automatic drive(input int s, input logic v, input logic [7:0] d);
      if (s == 0) begin
         rx_valid_a = v; rx_data_a = d;
      end else begin
         rx_valid_b = v; rx_data_b = d;
      end
   endtask

   function automatic logic rdy(input int s);
      return (s == 0) ? rx_ready_a : rx_ready_b;
   endfunction

   // Present one byte at a negedge and return at the negedge after it is accepted.
   task automatic send(input int s, input logic [7:0] b);
      int k;
      k = 0;
      drive(s, 1'b1, b);
      while (!rdy(s) && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: got rx_ready=0 for 50 cycles, expected 1");
      end
      @(negedge clk);
      if (throttle) begin
         drive(s, 1'b0, 8'h00);
         @(negedge clk);
      end
   endtask

   task automatic send_word(input int s, input logic [31:0] w);
      for (int i = 0; i < 4; i++) send(s, w[8*i +: 8]);
   endtask

   task automatic do_reset();
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push_a(input logic [11:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a; e.data = d;
      exp_a.push_back(e);
   endtask

   task automatic push_b(input logic [11:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a; e.data = d;
      exp_b.push_back(e);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      do_reset();
      // Reset values
      chk("rst_ready",  32'(rx_ready_a), 32'd1);
      chk("rst_we",     32'(mem_we_a), 32'd0);
      chk("rst_addr",   32'(mem_addr_a), 32'd3);
      chk("rst_wdata",  mem_wdata_a, 32'd0);
      chk("rst_done",   32'(load_done_a), 32'd0);
      chk("rst_err",    32'(load_error_a), 32'd0);
      chk("rst_words",  32'(words_loaded_a), 32'd0);

      // Two-word load, back-to-back, plus post-done bytes
      push_a(12'd3, 32'h0000_0013);
      push_a(12'd4, 32'h0010_0093);
      send_word(0, 32'd2);
      chk("check_ready", 32'(rx_ready_a), 32'd0);
      send_word(0, 32'h0000_0013);
      send_word(0, 32'h0010_0093);
      drive(0, 1'b0, 8'h00);
      chk("write_ready", 32'(rx_ready_a), 32'd0);
      chk("done_early", 32'(load_done_a), 32'd0);
      @(negedge clk);
      chk("two_done",  32'(load_done_a), 32'd1);
      chk("two_err",   32'(load_error_a), 32'd0);
      chk("two_words", 32'(words_loaded_a), 32'd2);
      drive(0, 1'b1, 8'h55);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_ready", 32'(rx_ready_a), 32'd0);
         chk("post_done",  32'(load_done_a), 32'd1);
      end
      do_reset();
      chk("post_rst_done", 32'(load_done_a), 32'd0);

      // Zero count
      send_word(0, 32'd0);
      drive(0, 1'b0, 8'h00);
      chk("zero_err_check", 32'(load_error_a), 32'd0);
      @(negedge clk);
      chk("zero_err",  32'(load_error_a), 32'd1);
      chk("zero_done", 32'(load_done_a), 32'd0);
      drive(0, 1'b1, 8'hAA);
      repeat (3) @(negedge clk);
      chk("zero_ready", 32'(rx_ready_a), 32'd0);
      do_reset();

      // Window bound with BASE_WORD=3: 4094 rejected, 4093 accepted
      send_word(0, 32'd4094);
      drive(0, 1'b0, 8'h00);
      @(negedge clk);
      chk("n4094_err", 32'(load_error_a), 32'd1);
      do_reset();
      send_word(0, 32'd4093);
      drive(0, 1'b0, 8'h00);
      @(negedge clk);
      chk("n4093_err",   32'(load_error_a), 32'd0);
      chk("n4093_ready", 32'(rx_ready_a), 32'd1);
      do_reset();
      // Upper header bits set
      send_word(0, 32'h8000_0001);
      drive(0, 1'b0, 8'h00);
      @(negedge clk);
      chk("hibit_err", 32'(load_error_a), 32'd1);
      do_reset();

      // Throttled two-word load
      throttle = 1'b1;
      cnt_en = 1'b1;
      idle_cnt = 0;
      push_a(12'd3, 32'h0000_0013);
      push_a(12'd4, 32'h0010_0093);
      send_word(0, 32'd2);
      send_word(0, 32'h0000_0013);
      send_word(0, 32'h0010_0093);
      chk("thr_done",  32'(load_done_a), 32'd1);
      chk("thr_words", 32'(words_loaded_a), 32'd2);
      cnt_en = 1'b0;
      chk("thr_idle_cycles", 32'(idle_cnt), 32'd3);
      throttle = 1'b0;
      do_reset();

      // Reset after the 2nd data byte of word 1, then a fresh 1-word load
      send_word(0, 32'd2);
      send(0, 8'h13);
      send(0, 8'h00);
      do_reset();
      chk("mid_rst_words", 32'(words_loaded_a), 32'd0);
      chk("mid_rst_ready", 32'(rx_ready_a), 32'd1);
      chk("mid_rst_addr",  32'(mem_addr_a), 32'd3);
      push_a(12'd3, 32'hDEAD_BEEF);
      send_word(0, 32'd1);
      send_word(0, 32'hDEAD_BEEF);
      drive(0, 1'b0, 8'h00);
      @(negedge clk);
      chk("fresh_done",  32'(load_done_a), 32'd1);
      chk("fresh_words", 32'(words_loaded_a), 32'd1);
      do_reset();

      // Instance B (ADDR_W=4): N=17 rejected, N=16 fills addresses 0..15
      send_word(1, 32'd17);
      drive(1, 1'b0, 8'h00);
      @(negedge clk);
      chk("b17_err", 32'(load_error_b), 32'd1);
      do_reset();
      for (int i = 0; i < 16; i++) push_b(12'(i), 32'hA5C3_0000 + 32'(i * 257));
      send_word(1, 32'd16);
      for (int i = 0; i < 16; i++) send_word(1, 32'hA5C3_0000 + 32'(i * 257));
      drive(1, 1'b0, 8'h00);
      @(negedge clk);
      chk("b16_done",  32'(load_done_b), 32'd1);
      chk("b16_err",   32'(load_error_b), 32'd0);
      chk("b16_words", 32'(words_loaded_b), 32'd16);

      repeat (3) @(negedge clk);
      chk("exp_a_drained", 32'(exp_a.size()), 32'd0);
      chk("exp_b_drained", 32'(exp_b.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
